// File: rtl/cselector_pkg.sv
// Shared definitions for the clocked N-way token selector: select legality
// check, occupancy width and the token layout for the default configuration.
package cselector_pkg;

   localparam int MAX_PORTS  = 16;
   localparam int DEF_PORTS  = 4;
   localparam int DEF_WIDTH  = 32;
   localparam int DEF_DEPTH  = 4;
   localparam int CNT_W      = $clog2(DEF_DEPTH + 1);

   typedef struct packed {
      logic [DEF_PORTS-1:0] sel;
      logic [DEF_WIDTH-1:0] data;
   } token_t;

   // Masks narrower than MAX_PORTS are zero-extended by the caller.
   function automatic logic onehot_check(input logic [MAX_PORTS-1:0] mask);
      return (mask != '0) && ((mask & (mask - 1'b1)) == '0);
   endfunction

endpackage

// File: rtl/c_selector_n_sync_fifo.sv
// Token storage for c_selector_n_sync: DEPTH-entry circular buffer holding
// {sel, data}, with head presented combinationally from the read pointer.
module c_sel_fifo
   import cselector_pkg::*;
#(
   parameter int NUM_PORTS  = 4,
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         push,
   input  logic [NUM_PORTS-1:0]         pushSel,
   input  logic [DATA_WIDTH-1:0]        pushData,
   input  logic                         pop,
   output logic [NUM_PORTS-1:0]         headSel,
   output logic [DATA_WIDTH-1:0]        headData,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output logic                         full,
   output logic                         empty
);

   localparam int PTR_W  = $clog2(DEPTH);
   localparam int FCNT_W = $clog2(DEPTH + 1);

   typedef struct packed {
      logic [NUM_PORTS-1:0]  sel;
      logic [DATA_WIDTH-1:0] data;
   } entry_t;

   entry_t             mem [DEPTH];
   logic [PTR_W-1:0]   wrPtr;
   logic [PTR_W-1:0]   rdPtr;
   logic [FCNT_W-1:0]  countNext;
   logic               doPush;
   logic               doPop;
   entry_t             headEntry;
   entry_t             pushEntry;

   assign full   = (count == FCNT_W'(DEPTH));
   assign empty  = (count == '0);
   assign doPush = push & ~full;
   assign doPop  = pop & ~empty;

   assign pushEntry = '{sel: pushSel, data: pushData};
   assign headEntry = mem[rdPtr];
   assign headSel   = headEntry.sel;
   assign headData  = headEntry.data;

   always_comb begin
      countNext = count;
      case ({doPush, doPop})
         2'b10:   countNext = count + 1'b1;
         2'b01:   countNext = count - 1'b1;
         default: countNext = count;
      endcase
   end

   // Pointers wrap for free because DEPTH is a power of two.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wrPtr <= '0;
         rdPtr <= '0;
         count <= '0;
      end else begin
         if (doPush) wrPtr <= wrPtr + 1'b1;
         if (doPop)  rdPtr <= rdPtr + 1'b1;
         count <= countNext;
      end
   end

   // Storage carries no reset so it maps onto plain RAM/LUTRAM.
   always_ff @(posedge clk) begin
      if (doPush) mem[wrPtr] <= pushEntry;
   end

endmodule

// File: rtl/c_selector_n_sync.sv
// Clocked N-way token selector: buffers {select, data} tokens and steers the
// head to its selected port(s). Optional macro CSELECTOR_MULTICAST_EN enables multicast.
module c_selector_n_sync
   import cselector_pkg::*;
#(
   parameter int NUM_PORTS  = 4,
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         i_drive,
   input  logic [NUM_PORTS-1:0]         i_select,
   input  logic [DATA_WIDTH-1:0]        i_data,
   output logic                         o_free,
   output logic [NUM_PORTS-1:0]         o_driveNext,
   input  logic [NUM_PORTS-1:0]         i_freeNext,
   output logic [DATA_WIDTH-1:0]        o_data,
   output logic [$clog2(DEPTH+1)-1:0]   o_count,
   output logic                         o_err
);

   logic [NUM_PORTS-1:0]       headSel;
   logic [DATA_WIDTH-1:0]      headData;
   logic [$clog2(DEPTH+1)-1:0] count;
   logic                       full;
   logic                       empty;
   logic [NUM_PORTS-1:0]       doneMask;
   logic [NUM_PORTS-1:0]       driveNext;
   logic [NUM_PORTS-1:0]       accepts;
   logic [MAX_PORTS-1:0]       selWide;
   logic                       legal;
   logic                       accept;
   logic                       push;
   logic                       pop;
   logic                       errReg;
   logic [DATA_WIDTH-1:0]      dataHold;

   always_comb begin
      selWide = '0;
      selWide[NUM_PORTS-1:0] = i_select;
   end

`ifdef CSELECTOR_MULTICAST_EN
   assign legal = |i_select;
`else
   assign legal = onehot_check(selWide);
`endif

   // Illegal tokens are still consumed so the producer never stalls on them.
   assign accept = i_drive & o_free;
   assign push   = accept & legal;

   c_sel_fifo #(
      .NUM_PORTS  (NUM_PORTS),
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH)
   ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .push     (push),
      .pushSel  (i_select),
      .pushData (i_data),
      .pop      (pop),
      .headSel  (headSel),
      .headData (headData),
      .count    (count),
      .full     (full),
      .empty    (empty)
   );

   genvar gi;
   generate
      for (gi = 0; gi < NUM_PORTS; gi++) begin : g_port
         assign driveNext[gi] = ~empty & headSel[gi] & ~doneMask[gi];
         assign accepts[gi]   = driveNext[gi] & i_freeNext[gi];
      end
   endgenerate

`ifdef CSELECTOR_MULTICAST_EN
   // Head leaves only once every selected port has taken it, in any order.
   assign pop = ~empty & (((doneMask | accepts) & headSel) == headSel);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)      doneMask <= '0;
      else if (pop) doneMask <= '0;
      else          doneMask <= doneMask | accepts;
   end
`else
   assign doneMask = '0;
   assign pop      = |accepts;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         errReg   <= 1'b0;
         dataHold <= '0;
      end else begin
         errReg <= accept & ~legal;
         if (!empty) dataHold <= headData;
      end
   end

   assign o_free      = ~full;
   assign o_driveNext = driveNext;
   assign o_data      = empty ? dataHold : headData;
   assign o_count     = count;
   assign o_err       = errReg;

endmodule

// File: tb/tb_c_selector_n_sync.sv
// Directed bench for c_selector_n_sync (default 4 ports, 32-bit data, depth 4);
// multicast expectations follow CSELECTOR_MULTICAST_EN when it is defined.
module tb_c_selector_n_sync;

`ifdef CSELECTOR_MULTICAST_EN
   localparam bit MC = 1'b1;
`else
   localparam bit MC = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        iDrive = 1'b0;
   logic [3:0]  iSelect = '0;
   logic [31:0] iData = '0;
   logic [3:0]  iFreeNext = '0;
   logic        oFree;
   logic [3:0]  oDriveNext;
   logic [31:0] oData;
   logic [2:0]  oCount;
   logic        oErr;

   int checks = 0;
   int errors = 0;

   c_selector_n_sync #(
      .NUM_PORTS  (4),
      .DATA_WIDTH (32),
      .DEPTH      (4)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .i_drive     (iDrive),
      .i_select    (iSelect),
      .i_data      (iData),
      .o_free      (oFree),
      .o_driveNext (oDriveNext),
      .i_freeNext  (iFreeNext),
      .o_data      (oData),
      .o_count     (oCount),
      .o_err       (oErr)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        drive;
      logic [3:0]  sel;
      logic [31:0] data;
      logic [3:0]  free;
      logic [3:0]  expDrive;
      logic [31:0] expData;
      logic [2:0]  expCount;
      logic        expFree;
      logic        expErr;
   } vec_t;

   vec_t vecs[10];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end else begin
         $display("ok   %s: %h", name, act);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chkAll(input string tag, input logic [3:0] d, input logic [31:0] dat,
                         input logic [2:0] c, input logic f, input logic e);
      chk({tag, ".drive"}, 32'(oDriveNext), 32'(d));
      chk({tag, ".data"},  oData, dat);
      chk({tag, ".count"}, 32'(oCount), 32'(c));
      chk({tag, ".free"},  32'(oFree), 32'(f));
      chk({tag, ".err"},   32'(oErr), 32'(e));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [3:0] badSel2;
      badSel2 = MC ? 4'b0000 : 4'b0011;

      //            drv   sel      data          free     expDrv   expData       cnt   free  err
      vecs[0] = '{1'b1, 4'b0100, 32'hA5A5_0001, 4'b0100, 4'b0000, 32'h0000_0000, 3'd0, 1'b1, 1'b0};
      vecs[1] = '{1'b0, 4'b0000, 32'h0,         4'b0100, 4'b0100, 32'hA5A5_0001, 3'd1, 1'b1, 1'b0};
      vecs[2] = '{1'b1, 4'b0000, 32'h0000_0001, 4'b0000, 4'b0000, 32'hA5A5_0001, 3'd0, 1'b1, 1'b0};
      vecs[3] = '{1'b1, badSel2, 32'h0000_0002, 4'b0000, 4'b0000, 32'hA5A5_0001, 3'd0, 1'b1, 1'b1};
      vecs[4] = '{1'b0, 4'b0000, 32'h0,         4'b0000, 4'b0000, 32'hA5A5_0001, 3'd0, 1'b1, 1'b1};
      vecs[5] = '{1'b1, 4'b0001, 32'h1111_1111, 4'b0001, 4'b0000, 32'hA5A5_0001, 3'd0, 1'b1, 1'b0};
      vecs[6] = '{1'b1, 4'b1000, 32'h2222_2222, 4'b0001, 4'b0001, 32'h1111_1111, 3'd1, 1'b1, 1'b0};
      vecs[7] = '{1'b0, 4'b0000, 32'h0,         4'b0111, 4'b1000, 32'h2222_2222, 3'd1, 1'b1, 1'b0};
      vecs[8] = '{1'b0, 4'b0000, 32'h0,         4'b1000, 4'b1000, 32'h2222_2222, 3'd1, 1'b1, 1'b0};
      vecs[9] = '{1'b0, 4'b0000, 32'h0,         4'b0000, 4'b0000, 32'h2222_2222, 3'd0, 1'b1, 1'b0};

      // Reset state
      tick();
      tick();
      chkAll("reset", 4'b0000, 32'h0, 3'd0, 1'b1, 1'b0);
      rst = 1'b0;

      // Single token, illegal selects, push/pop overlap, ignored free bits
      for (int i = 0; i < 10; i++) begin
         chkAll($sformatf("vec%0d", i), vecs[i].expDrive, vecs[i].expData,
                vecs[i].expCount, vecs[i].expFree, vecs[i].expErr);
         iDrive    = vecs[i].drive;
         iSelect   = vecs[i].sel;
         iData     = vecs[i].data;
         iFreeNext = vecs[i].free;
         tick();
      end

      // Fill to DEPTH, fifth token held, no bypass on the pop cycle
      for (int c = 0; c < 4; c++) begin
         chk($sformatf("fill%0d.count", c), 32'(oCount), 32'(c));
         chk($sformatf("fill%0d.free", c), 32'(oFree), 32'd1);
         iDrive = 1'b1; iSelect = 4'b0001; iData = 32'h100 + 32'(c); iFreeNext = 4'b0000;
         tick();
      end
      chkAll("full", 4'b0001, 32'h100, 3'd4, 1'b0, 1'b0);
      iData = 32'h104;
      tick();
      chk("held1.count", 32'(oCount), 32'd4);
      tick();
      chk("held2.count", 32'(oCount), 32'd4);
      chk("popcyc.free", 32'(oFree), 32'd0);
      iFreeNext = 4'b0001;
      tick();
      chkAll("afterpop", 4'b0001, 32'h101, 3'd3, 1'b1, 1'b0);
      iFreeNext = 4'b0000;
      tick();
      chk("refill.count", 32'(oCount), 32'd4);
      chk("refill.free", 32'(oFree), 32'd0);
      iDrive = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         chk($sformatf("drain%0d.data", k), oData, 32'h100 + 32'(k));
         chk($sformatf("drain%0d.drive", k), 32'(oDriveNext), 32'b0001);
         iFreeNext = 4'b0001;
         tick();
      end
      iFreeNext = 4'b0000;
      chkAll("drained", 4'b0000, 32'h104, 3'd0, 1'b1, 1'b0);

      // Backpressure hold for 10 cycles, accepted on the 11th
      iDrive = 1'b1; iSelect = 4'b0010; iData = 32'hDEAD_BEEF;
      tick();
      iDrive = 1'b0;
      for (int k = 0; k < 10; k++) begin
         chk($sformatf("hold%0d.drive", k), 32'(oDriveNext), 32'b0010);
         chk($sformatf("hold%0d.data", k), oData, 32'hDEAD_BEEF);
         tick();
      end
      chk("hold10.drive", 32'(oDriveNext), 32'b0010);
      iFreeNext = 4'b0010;
      tick();
      iFreeNext = 4'b0000;
      chkAll("holddone", 4'b0000, 32'hDEAD_BEEF, 3'd0, 1'b1, 1'b0);

      // Multi-hot select 1011
      iDrive = 1'b1; iSelect = 4'b1011; iData = 32'hCAFE_0001;
      tick();
      iDrive = 1'b0;
      if (MC) begin
         chk("mc1.drive", 32'(oDriveNext), 32'b1011);
         iFreeNext = 4'b0001;
         tick();
         chk("mc2.drive", 32'(oDriveNext), 32'b1010);
         iFreeNext = 4'b0000;
         tick();
         chk("mc3.drive", 32'(oDriveNext), 32'b1010);
         iFreeNext = 4'b1000;
         tick();
         chkAll("mc4", 4'b0010, 32'hCAFE_0001, 3'd1, 1'b1, 1'b0);
         iFreeNext = 4'b0000;
         tick();
         chk("mc5.drive", 32'(oDriveNext), 32'b0010);
         iFreeNext = 4'b0010;
         tick();
         iFreeNext = 4'b0000;
         chkAll("mcdone", 4'b0000, 32'hCAFE_0001, 3'd0, 1'b1, 1'b0);
      end else begin
         chkAll("multihot", 4'b0000, 32'hDEAD_BEEF, 3'd0, 1'b1, 1'b1);
         tick();
         chk("multihot.errclr", 32'(oErr), 32'd0);
      end

      // Asynchronous reset with three tokens queued
      for (int k = 0; k < 3; k++) begin
         iDrive = 1'b1; iSelect = 4'b0100; iData = 32'h300 + 32'(k);
         tick();
      end
      iDrive = 1'b0;
      chk("queued.count", 32'(oCount), 32'd3);
      #2;
      rst = 1'b1;
      #1;
      chkAll("asyncrst", 4'b0000, 32'h0, 3'd0, 1'b1, 1'b0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      iDrive = 1'b1; iSelect = 4'b0100; iData = 32'h0000_0077; iFreeNext = 4'b0100;
      tick();
      iDrive = 1'b0;
      chkAll("postrst", 4'b0100, 32'h77, 3'd1, 1'b1, 1'b0);
      tick();
      iFreeNext = 4'b0000;
      chk("postrst.popcount", 32'(oCount), 32'd0);
      chk("postrst.popdrive", 32'(oDriveNext), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
